// File: rtl/vga_pkg.sv
// Shared VGA timing package: default 640x480@60 timing, sync polarity
// constants and a helper that derives counter period and width.
package vga_pkg;

    // Default 640x480@60 timing (pixel clocks / lines)
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    // Asserted level of a sync output
    localparam bit SYNC_ACTIVE_LOW  = 1'b0;
    localparam bit SYNC_ACTIVE_HIGH = 1'b1;

    // Period of one scan dimension and the counter width needed to hold it
    typedef struct packed {
        logic [31:0] total;
        logic [31:0] width;
    } timing_dim_t;

    function automatic timing_dim_t calc_timing_dim(
        input int unsigned active,
        input int unsigned fp,
        input int unsigned sync,
        input int unsigned bp
    );
        timing_dim_t d;
        d.total = active + fp + sync + bp;
        d.width = $clog2(d.total);
        return d;
    endfunction

endpackage

// File: rtl/vga_band_match.sv
// Combinational hit test of one rectangular band [x0,x1) x [y0,y1).
// An empty or inverted extent can never satisfy both bounds, so it never hits.
module vga_band_match #(
    parameter int unsigned HW = 10,
    parameter int unsigned VW = 10
) (
    input  logic [HW-1:0] h,
    input  logic [VW-1:0] v,
    input  logic [HW-1:0] x0,
    input  logic [HW-1:0] x1,
    input  logic [VW-1:0] y0,
    input  logic [VW-1:0] y1,
    output logic          hit
);

    assign hit = (h >= x0) && (h < x1) && (v >= y0) && (v < y1);

endmodule

// File: rtl/vga_band_scanout.sv
// VGA scan-out engine: programmable sync timing, up to NUM_BANDS priority
// colour bands over a background. Band geometry lives in shadow registers
// that are refreshed only at the start of vertical blank, so frames never tear.
module vga_band_scanout
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
    parameter int unsigned H_FP      = DEF_H_FP,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BP      = DEF_H_BP,
    parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE,
    parameter int unsigned V_FP      = DEF_V_FP,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BP      = DEF_V_BP,
    parameter bit          HSYNC_POL = SYNC_ACTIVE_LOW,
    parameter bit          VSYNC_POL = SYNC_ACTIVE_LOW,
    parameter int unsigned RGB_W     = 3,
    parameter int unsigned NUM_BANDS = 4,
    localparam timing_dim_t H_DIM = calc_timing_dim(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam timing_dim_t V_DIM = calc_timing_dim(V_ACTIVE, V_FP, V_SYNC, V_BP),
    localparam int unsigned HW = H_DIM.width,
    localparam int unsigned VW = V_DIM.width
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_BANDS*HW-1:0]    band_x0,
    input  logic [NUM_BANDS*HW-1:0]    band_x1,
    input  logic [NUM_BANDS*VW-1:0]    band_y0,
    input  logic [NUM_BANDS*VW-1:0]    band_y1,
    input  logic [NUM_BANDS*RGB_W-1:0] band_color,
    input  logic [RGB_W-1:0]           bg_color,
    input  logic                       update_req,
    output logic                       update_ack,
    output logic                       hsync,
    output logic                       vsync,
    output logic [RGB_W-1:0]           rgb,
    output logic [HW-1:0]              hcount,
    output logic [VW-1:0]              vcount,
    output logic                       active,
    output logic                       frame_start
);

    localparam int unsigned H_TOTAL  = H_DIM.total;
    localparam int unsigned V_TOTAL  = V_DIM.total;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          h_wrap;
    logic          v_wrap;
    logic          commit;

    logic [NUM_BANDS*HW-1:0]    sh_x0;
    logic [NUM_BANDS*HW-1:0]    sh_x1;
    logic [NUM_BANDS*VW-1:0]    sh_y0;
    logic [NUM_BANDS*VW-1:0]    sh_y1;
    logic [NUM_BANDS*RGB_W-1:0] sh_color;
    logic [RGB_W-1:0]           sh_bg;

    logic [NUM_BANDS-1:0] band_hit;
    logic [RGB_W-1:0]     pix_color;
    logic                 active_c;
    logic                 hs_on;
    logic                 vs_on;

    assign h_wrap = (32'(h_cnt) == H_TOTAL - 1);
    assign v_wrap = (32'(v_cnt) == V_TOTAL - 1);

    // First blank line, first pixel: the only place the shadows may change
    assign commit = update_req && (h_cnt == '0) && (32'(v_cnt) == V_ACTIVE);

    assign active_c = (32'(h_cnt) < H_ACTIVE) && (32'(v_cnt) < V_ACTIVE);
    assign hs_on    = (32'(h_cnt) >= HS_START) && (32'(h_cnt) < HS_END);
    assign vs_on    = (32'(v_cnt) >= VS_START) && (32'(v_cnt) < VS_END);

    // Raster position counters: h runs along a line, v advances on each line wrap
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_wrap) begin
            h_cnt <= '0;
            v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    // Shadow geometry, captured from the live inputs only at the commit point
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: the shadows are reset on purpose: all-zero geometry is the defined "no bands" state.
        if (reset) begin
            sh_x0    <= '0;
            sh_x1    <= '0;
            sh_y0    <= '0;
            sh_y1    <= '0;
            sh_color <= '0;
            sh_bg    <= '0;
        end else if (commit) begin
            sh_x0    <= band_x0;
            sh_x1    <= band_x1;
            sh_y0    <= band_y0;
            sh_y1    <= band_y1;
            sh_color <= band_color;
            sh_bg    <= bg_color;
        end
    end

    for (genvar i = 0; i < NUM_BANDS; i++) begin : g_band
        vga_band_match #(
            .HW (HW),
            .VW (VW)
        ) u_match (
            .h   (h_cnt),
            .v   (v_cnt),
            .x0  (sh_x0[i*HW +: HW]),
            .x1  (sh_x1[i*HW +: HW]),
            .y0  (sh_y0[i*VW +: VW]),
            .y1  (sh_y1[i*VW +: VW]),
            .hit (band_hit[i])
        );
    end

    // Priority select: scanning from the top index down leaves the lowest hitting band in place
    always_comb begin
        // NOTE: default assignment first keeps this purely combinational (no latch).
        pix_color = sh_bg;
        for (int i = NUM_BANDS - 1; i >= 0; i--) begin
            if (band_hit[i]) begin
                pix_color = sh_color[i*RGB_W +: RGB_W];
            end
        end
    end

    // Output registers: everything is derived from the same counter state, so all stay aligned
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            rgb         <= '0;
            hcount      <= '0;
            vcount      <= '0;
            active      <= 1'b0;
            frame_start <= 1'b0;
            update_ack  <= 1'b0;
        end else begin
            hsync       <= hs_on ? HSYNC_POL : ~HSYNC_POL;
            vsync       <= vs_on ? VSYNC_POL : ~VSYNC_POL;
            rgb         <= active_c ? pix_color : '0;
            hcount      <= h_cnt;
            vcount      <= v_cnt;
            active      <= active_c;
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
            update_ack  <= commit;
        end
    end

endmodule

// File: tb/tb_vga_band_scanout.sv
// Self-checking bench for vga_band_scanout on a reduced raster (24 x 17
// clocks per frame). A raster model derives every expected output from the
// cycle index since reset release and keeps its own copy of the committed
// band geometry.
module tb_vga_band_scanout;
    import vga_pkg::*;

    localparam int HA = 16, HF = 2, HS = 3, HB = 3;
    localparam int VA = 10, VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;   // 24
    localparam int VT = VA + VF + VS + VB;   // 17
    localparam int FT = HT * VT;             // 408
    localparam int NB = 4;
    localparam int HW = 5;                   // clog2(24)
    localparam int VW = 5;                   // clog2(17)
    localparam int RW = 3;
    localparam bit HPOL = SYNC_ACTIVE_LOW;
    localparam bit VPOL = SYNC_ACTIVE_HIGH;
    localparam int COMMIT_POS = VA * HT;

    logic              clk = 1'b0;
    logic              reset;
    logic [NB*HW-1:0]  band_x0, band_x1;
    logic [NB*VW-1:0]  band_y0, band_y1;
    logic [NB*RW-1:0]  band_color;
    logic [RW-1:0]     bg_color;
    logic              update_req;
    logic              update_ack;
    logic              hsync, vsync;
    logic [RW-1:0]     rgb;
    logic [HW-1:0]     hcount;
    logic [VW-1:0]     vcount;
    logic              active;
    logic              frame_start;

    always #5 clk = ~clk;

    vga_band_scanout #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .HSYNC_POL (HPOL), .VSYNC_POL (VPOL),
        .RGB_W (RW), .NUM_BANDS (NB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .band_x0     (band_x0),
        .band_x1     (band_x1),
        .band_y0     (band_y0),
        .band_y1     (band_y1),
        .band_color  (band_color),
        .bg_color    (bg_color),
        .update_req  (update_req),
        .update_ack  (update_ack),
        .hsync       (hsync),
        .vsync       (vsync),
        .rgb         (rgb),
        .hcount      (hcount),
        .vcount      (vcount),
        .active      (active),
        .frame_start (frame_start)
    );

    typedef struct {
        int x0;
        int x1;
        int y0;
        int y1;
        int col;
    } band_t;

    band_t live [NB];
    band_t sh   [NB];
    int    live_bg;
    int    sh_bg;
    int    e;          // clock edges since reset release
    int    last_fs;
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0d expected %0d (edge %0d, t=%0t)", tag, act, exp, e, $time);
        end
    endtask

    // Colour the model expects at raster position (h, v)
    function automatic int model_rgb(input int h, input int v);
        if (!(h < HA && v < VA)) return 0;
        for (int i = 0; i < NB; i++)
            if (h >= sh[i].x0 && h < sh[i].x1 && v >= sh[i].y0 && v < sh[i].y1)
                return sh[i].col;
        return sh_bg;
    endfunction

    task automatic drive_live();
        for (int i = 0; i < NB; i++) begin
            band_x0[i*HW +: HW]    = HW'(live[i].x0);
            band_x1[i*HW +: HW]    = HW'(live[i].x1);
            band_y0[i*VW +: VW]    = VW'(live[i].y0);
            band_y1[i*VW +: VW]    = VW'(live[i].y1);
            band_color[i*RW +: RW] = RW'(live[i].col);
        end
        bg_color = RW'(live_bg);
    endtask

    task automatic randomize_live();
        for (int i = 0; i < NB; i++) begin
            live[i].x0  = $urandom_range(0, 31);
            live[i].x1  = $urandom_range(0, 31);
            live[i].y0  = $urandom_range(0, 31);
            live[i].y1  = $urandom_range(0, 31);
            live[i].col = $urandom_range(0, 7);
        end
        live_bg = $urandom_range(0, 7);
        drive_live();
    endtask

    task automatic set_band(input int i, input int x0, input int x1, input int y0, input int y1, input int col);
        live[i].x0 = x0; live[i].x1 = x1; live[i].y0 = y0; live[i].y1 = y1; live[i].col = col;
    endtask

    task automatic clear_live();
        for (int i = 0; i < NB; i++) set_band(i, 0, 0, 0, 0, 0);
        live_bg = 0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NB; i++) sh[i] = '{0, 0, 0, 0, 0};
        sh_bg   = 0;
        e       = 0;
        last_fs = -1;
    endtask

    task automatic check_reset_values();
        check("rst_rgb",    rgb, 0);
        check("rst_hcount", hcount, 0);
        check("rst_vcount", vcount, 0);
        check("rst_active", active, 0);
        check("rst_fstart", frame_start, 0);
        check("rst_ack",    update_ack, 0);
        check("rst_hsync",  hsync, 32'(!HPOL));
        check("rst_vsync",  vsync, 32'(!VPOL));
    endtask

    // One clock edge: predict from raster position, then compare all outputs
    task automatic step();
        int pos, h, v, exp_rgb;
        bit do_commit;
        @(posedge clk);
        pos = e % FT;
        h   = pos % HT;
        v   = pos / HT;
        e++;
        do_commit = (h == 0) && (v == VA) && (update_req === 1'b1);
        exp_rgb   = model_rgb(h, v);
        if (do_commit) begin
            for (int i = 0; i < NB; i++) sh[i] = live[i];
            sh_bg = live_bg;
        end
        #1;
        check("hcount", hcount, h);
        check("vcount", vcount, v);
        check("active", active, (h < HA && v < VA) ? 1 : 0);
        check("rgb",    rgb, exp_rgb);
        check("hsync",  hsync, (h >= HA + HF && h < HA + HF + HS) ? 32'(HPOL) : 32'(!HPOL));
        check("vsync",  vsync, (v >= VA + VF && v < VA + VF + VS) ? 32'(VPOL) : 32'(!VPOL));
        check("frame_start", frame_start, (pos == 0) ? 1 : 0);
        check("update_ack",  update_ack, do_commit ? 1 : 0);
        if (frame_start === 1'b1) begin
            if (last_fs >= 0) check("fs_period", e - last_fs, FT);
            last_fs = e;
        end
    endtask

    // Idle cycles: live inputs churn freely whenever no request is pending
    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            if (!update_req) randomize_live();
            step();
        end
    endtask

    task automatic run_to_pos(input int target);
        for (int k = 0; k < FT && (e % FT) != target; k++) idle_cycles(1);
    endtask

    // Raise a request with the current live values and hold it until ack
    task automatic commit_and_wait(input string tag);
        int cnt;
        drive_live();
        update_req = 1'b1;
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (update_ack !== 1'b1 && cnt < 2 * FT);
        check(tag, update_ack, 1);
        update_req = 1'b0;
    endtask

    initial begin
        int cnt;
        reset      = 1'b1;
        update_req = 1'b0;
        clear_live();
        drive_live();
        model_reset();

        @(posedge clk);
        #1;
        check_reset_values();
        reset = 1'b0;

        // No commit yet: two frames of blank-coloured raster, sync timing only
        idle_cycles(2 * FT);

        // Single full-width band on rows 2..3, requested mid-frame at v = 5
        run_to_pos(5 * HT);
        clear_live();
        set_band(0, 0, HA, 2, 4, 3'b100);
        live_bg = 3'b011;
        commit_and_wait("ack_band0");
        check("ack_pos", (e - 1) % FT, COMMIT_POS);
        idle_cycles(FT);

        // Overlap: lower index wins inside its rectangle
        clear_live();
        set_band(0, 2, 5, 2, 5, 3'b001);
        set_band(1, 0, HA, 0, VA, 3'b010);
        live_bg = 3'b111;
        commit_and_wait("ack_overlap");
        idle_cycles(FT);

        // Empty and inverted bands are never drawn
        clear_live();
        set_band(0, 5, 5, 0, VA, 3'b110);
        set_band(1, 9, 4, 0, VA, 3'b111);
        set_band(2, 0, HA, 6, 6, 3'b001);
        live_bg = 3'b101;
        commit_and_wait("ack_empty");
        idle_cycles(FT);

        // Request raised exactly on the commit cycle is accepted at once
        run_to_pos(COMMIT_POS);
        randomize_live();
        update_req = 1'b1;
        step();
        check("ack_exact", update_ack, 1);
        update_req = 1'b0;
        idle_cycles(FT);

        // Request raised one cycle late waits a whole frame
        run_to_pos(COMMIT_POS + 1);
        randomize_live();
        update_req = 1'b1;
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (update_ack !== 1'b1 && cnt < 2 * FT);
        check("ack_late_delay", cnt, FT);
        update_req = 1'b0;
        idle_cycles(FT);

        // Randomized requests at arbitrary times against churning live inputs
        for (int k = 0; k < 10 * FT; k++) begin
            if (!update_req) begin
                randomize_live();
                if ($urandom_range(0, 199) == 0) update_req = 1'b1;
            end
            step();
            if (update_req && update_ack === 1'b1) update_req = 1'b0;
        end
        update_req = 1'b0;

        // Make sure something non-blank is committed before the reset test
        clear_live();
        set_band(0, 0, HA, 0, VA, 3'b110);
        live_bg = 3'b001;
        commit_and_wait("ack_pre_reset");

        // Reset mid-frame at (h 7, v 5): outputs drop at once, shadows clear
        run_to_pos(5 * HT + 7);
        #3;
        reset = 1'b1;
        #1;
        check_reset_values();
        repeat (2) @(posedge clk);
        #1;
        check_reset_values();
        model_reset();
        reset = 1'b0;
        idle_cycles(FT + HT);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
